// File: rtl/pc_fetch_stage.sv
// Program-counter register and instruction-fetch controller.
// Holds the architectural PC, fetches one instruction word at a time over a
// req/gnt/rvalid handshake, presents {PC, instruction} downstream and commits
// the returned next PC on a valid/ready handshake. Misaligned next-PC values
// and memory timeouts park the stage in TRAP until reset.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 32
) (
    input  logic             i_Clk,
    input  logic             i_Reset_n,
    output logic             o_Imem_Req,
    output logic [31:0]      o_Imem_Addr,
    input  logic             i_Imem_Gnt,
    input  logic             i_Imem_Rvalid,
    input  logic [31:0]      i_Imem_Rdata,
    output logic             o_Valid,
    output logic [31:0]      o_Pc,
    output logic [31:0]      o_Instruction,
    input  logic             i_Ready,
    input  logic [31:0]      i_Next,
    output logic             o_Misaligned,
    output logic             o_Timeout,
    output logic [CNT_W-1:0] o_Fetch_Count
);

    // Wait counter only has to reach TIMEOUT-1, so size it to that.
    localparam int                 WCNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0]  WAIT_LIMIT = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_TRAP
    } state_e;

    state_e             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               mis_q, mis_d;
    logic               tmo_q, tmo_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WCNT_W-1:0]  wait_q, wait_d;

    // State and datapath registers; reset abandons any in-flight request.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic: REQ -> WAIT -> HOLD -> REQ, with TRAP as a dead end.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        mis_d   = mis_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        wait_d  = wait_q;
        unique case (state_q)
            S_REQ: begin
                // Stale rvalid from an abandoned request is ignored here.
                if (i_Imem_Gnt) begin
                    state_d = S_WAIT;
                    wait_d  = '0;
                end
            end
            S_WAIT: begin
                // Data arriving on the limit cycle still wins over the trap.
                if (i_Imem_Rvalid) begin
                    instr_d = i_Imem_Rdata;
                    state_d = S_HOLD;
                end else if (wait_q == WAIT_LIMIT) begin
                    tmo_d   = 1'b1;
                    state_d = S_TRAP;
                end else begin
                    wait_d = wait_q + WCNT_W'(1);
                end
            end
            S_HOLD: begin
                if (i_Ready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (i_Next[1:0] == 2'b00) begin
                        pc_d    = i_Next;
                        state_d = S_REQ;
                    end else begin
                        mis_d   = 1'b1;
                        state_d = S_TRAP;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
        valid_d = (state_d == S_HOLD);
    end

    assign o_Imem_Req    = (state_q == S_REQ);
    assign o_Imem_Addr   = pc_q;
    assign o_Valid       = valid_q;
    assign o_Pc          = pc_q;
    assign o_Instruction = instr_q;
    assign o_Misaligned  = mis_q;
    assign o_Timeout     = tmo_q;
    assign o_Fetch_Count = cnt_q;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus randomized
// fetch traffic checked against a transaction-level PC/count model.
module tb_pc_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;
    localparam int          CNT_W    = 4;

    logic             i_Clk;
    logic             i_Reset_n;
    logic             o_Imem_Req;
    logic [31:0]      o_Imem_Addr;
    logic             i_Imem_Gnt;
    logic             i_Imem_Rvalid;
    logic [31:0]      i_Imem_Rdata;
    logic             o_Valid;
    logic [31:0]      o_Pc;
    logic [31:0]      o_Instruction;
    logic             i_Ready;
    logic [31:0]      i_Next;
    logic             o_Misaligned;
    logic             o_Timeout;
    logic [CNT_W-1:0] o_Fetch_Count;

    int checks = 0;
    int errors = 0;

    // Reference model: architectural PC and number of handshakes so far.
    logic [31:0] m_pc;
    int          m_cnt;

    pc_fetch_stage #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .i_Clk        (i_Clk),
        .i_Reset_n    (i_Reset_n),
        .o_Imem_Req   (o_Imem_Req),
        .o_Imem_Addr  (o_Imem_Addr),
        .i_Imem_Gnt   (i_Imem_Gnt),
        .i_Imem_Rvalid(i_Imem_Rvalid),
        .i_Imem_Rdata (i_Imem_Rdata),
        .o_Valid      (o_Valid),
        .o_Pc         (o_Pc),
        .o_Instruction(o_Instruction),
        .i_Ready      (i_Ready),
        .i_Next       (i_Next),
        .o_Misaligned (o_Misaligned),
        .o_Timeout    (o_Timeout),
        .o_Fetch_Count(o_Fetch_Count)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Advance one clock; afterwards outputs are settled and inputs may change.
    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] exp_cnt();
        int v;
        v = m_cnt % (1 << CNT_W);
        return v[CNT_W-1:0];
    endfunction

    task automatic apply_reset();
        i_Reset_n     = 1'b0;
        i_Imem_Gnt    = 1'b0;
        i_Imem_Rvalid = 1'b0;
        i_Imem_Rdata  = 32'h0;
        i_Ready       = 1'b0;
        i_Next        = 32'h0;
        step();
        step();
        i_Reset_n = 1'b1;
        m_pc      = RESET_PC;
        m_cnt     = 0;
    endtask

    // Simple fetch: gnt at once, rvalid the next cycle; ends in HOLD.
    task automatic do_fetch(input logic [31:0] data);
        i_Imem_Gnt = 1'b1;
        step();
        i_Imem_Gnt    = 1'b0;
        i_Imem_Rvalid = 1'b1;
        i_Imem_Rdata  = data;
        step();
        i_Imem_Rvalid = 1'b0;
    endtask

    task automatic test_reset();
        i_Reset_n     = 1'b0;
        i_Imem_Gnt    = 1'b0;
        i_Imem_Rvalid = 1'b0;
        i_Imem_Rdata  = 32'h0;
        i_Ready       = 1'b0;
        i_Next        = 32'h0;
        step();
        step();
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_Valid); end
        checks++; if (o_Pc !== RESET_PC) begin errors++; $display("FAIL reset_pc: got %h expected %h", o_Pc, RESET_PC); end
        checks++; if (o_Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", o_Instruction); end
        checks++; if (o_Misaligned !== 1'b0 || o_Timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got mis=%b tmo=%b expected 0/0", o_Misaligned, o_Timeout); end
        checks++; if (o_Fetch_Count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", o_Fetch_Count); end
        checks++; if (o_Imem_Req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", o_Imem_Req); end
        i_Reset_n = 1'b1;
        m_pc      = RESET_PC;
        m_cnt     = 0;
    endtask

    task automatic test_basic_fetch();
        checks++; if (o_Imem_Req !== 1'b1 || o_Imem_Addr !== RESET_PC) begin errors++; $display("FAIL basic_req: got req=%b addr=%h expected 1/%h", o_Imem_Req, o_Imem_Addr, RESET_PC); end
        i_Imem_Gnt = 1'b1;
        step();
        i_Imem_Gnt = 1'b0;
        checks++; if (o_Imem_Req !== 1'b0 || o_Valid !== 1'b0) begin errors++; $display("FAIL basic_wait: got req=%b valid=%b expected 0/0", o_Imem_Req, o_Valid); end
        i_Imem_Rvalid = 1'b1;
        i_Imem_Rdata  = 32'h2010_0005;
        step();
        i_Imem_Rvalid = 1'b0;
        checks++; if (o_Valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", o_Valid); end
        checks++; if (o_Pc !== 32'h0) begin errors++; $display("FAIL basic_pc: got %h expected 0", o_Pc); end
        checks++; if (o_Instruction !== 32'h2010_0005) begin errors++; $display("FAIL basic_instr: got %h expected 20100005", o_Instruction); end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            i_Ready = 1'b0;
            i_Next  = $urandom;
            step();
            checks++;
            if (o_Valid !== 1'b1 || o_Pc !== 32'h0 || o_Instruction !== 32'h2010_0005 || o_Fetch_Count !== '0) begin
                errors++;
                $display("FAIL stall_stable: got valid=%b pc=%h instr=%h cnt=%0d expected 1/0/20100005/0", o_Valid, o_Pc, o_Instruction, o_Fetch_Count);
            end
        end
        i_Ready = 1'b1;
        i_Next  = 32'h0000_0004;
        step();
        i_Ready = 1'b0;
        m_pc    = 32'h4;
        m_cnt   = 1;
        checks++; if (o_Imem_Req !== 1'b1 || o_Imem_Addr !== 32'h4) begin errors++; $display("FAIL stall_commit_addr: got req=%b addr=%h expected 1/4", o_Imem_Req, o_Imem_Addr); end
        checks++; if (o_Fetch_Count !== exp_cnt()) begin errors++; $display("FAIL stall_commit_count: got %0d expected %0d", o_Fetch_Count, exp_cnt()); end
        checks++; if (o_Valid !== 1'b0) begin errors++; $display("FAIL stall_commit_valid: got %b expected 0", o_Valid); end
    endtask

    task automatic test_gnt_delay();
        for (int i = 0; i < 3; i++) begin
            i_Imem_Gnt    = 1'b0;
            i_Imem_Rvalid = 1'b1;
            i_Imem_Rdata  = 32'hDEAD_BEEF;
            step();
            checks++;
            if (o_Imem_Req !== 1'b1 || o_Imem_Addr !== m_pc || o_Valid !== 1'b0) begin
                errors++;
                $display("FAIL gnt_delay_req: got req=%b addr=%h valid=%b expected 1/%h/0", o_Imem_Req, o_Imem_Addr, o_Valid, m_pc);
            end
        end
        i_Imem_Rvalid = 1'b0;
        do_fetch(32'h1234_5678);
        checks++; if (o_Valid !== 1'b1 || o_Instruction !== 32'h1234_5678 || o_Pc !== m_pc) begin errors++; $display("FAIL gnt_delay_data: got valid=%b instr=%h pc=%h expected 1/12345678/%h", o_Valid, o_Instruction, o_Pc, m_pc); end
        i_Ready = 1'b1;
        i_Next  = 32'h0000_0008;
        step();
        i_Ready = 1'b0;
        m_pc    = 32'h8;
        m_cnt++;
        checks++; if (o_Fetch_Count !== exp_cnt() || o_Imem_Addr !== m_pc) begin errors++; $display("FAIL gnt_delay_commit: got cnt=%0d addr=%h expected %0d/%h", o_Fetch_Count, o_Imem_Addr, exp_cnt(), m_pc); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 40; t++) begin
            int          gd;
            int          rd;
            int          sd;
            logic [31:0] data;
            logic [31:0] nxt;
            gd   = int'($urandom_range(3, 0));
            rd   = int'($urandom_range(TIMEOUT - 1, 0));
            sd   = int'($urandom_range(3, 0));
            data = $urandom;
            nxt  = $urandom & 32'hFFFF_FFFC;
            for (int i = 0; i < gd; i++) begin
                i_Imem_Gnt    = 1'b0;
                i_Imem_Rvalid = 1'($urandom_range(1, 0));
                i_Imem_Rdata  = $urandom;
                step();
            end
            i_Imem_Rvalid = 1'b0;
            checks++; if (o_Imem_Req !== 1'b1 || o_Imem_Addr !== m_pc) begin errors++; $display("FAIL rand_req[%0d]: got req=%b addr=%h expected 1/%h", t, o_Imem_Req, o_Imem_Addr, m_pc); end
            i_Imem_Gnt = 1'b1;
            step();
            i_Imem_Gnt = 1'b0;
            for (int i = 0; i < rd; i++) step();
            i_Imem_Rvalid = 1'b1;
            i_Imem_Rdata  = data;
            step();
            i_Imem_Rvalid = 1'b0;
            for (int i = 0; i < sd; i++) begin
                i_Next = $urandom;
                step();
            end
            checks++;
            if (o_Valid !== 1'b1 || o_Pc !== m_pc || o_Instruction !== data || o_Timeout !== 1'b0) begin
                errors++;
                $display("FAIL rand_hold[%0d]: got valid=%b pc=%h instr=%h tmo=%b expected 1/%h/%h/0", t, o_Valid, o_Pc, o_Instruction, o_Timeout, m_pc, data);
            end
            i_Ready = 1'b1;
            i_Next  = nxt;
            step();
            i_Ready = 1'b0;
            m_pc    = nxt;
            m_cnt++;
            checks++; if (o_Fetch_Count !== exp_cnt()) begin errors++; $display("FAIL rand_count[%0d]: got %0d expected %0d", t, o_Fetch_Count, exp_cnt()); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] prior;
        prior = m_pc;
        do_fetch(32'hCAFE_0001);
        i_Ready = 1'b1;
        i_Next  = 32'h0000_0042;
        step();
        i_Ready = 1'b0;
        m_cnt++;
        checks++; if (o_Misaligned !== 1'b1 || o_Timeout !== 1'b0) begin errors++; $display("FAIL mis_flag: got mis=%b tmo=%b expected 1/0", o_Misaligned, o_Timeout); end
        checks++; if (o_Pc !== prior) begin errors++; $display("FAIL mis_pc: got %h expected %h", o_Pc, prior); end
        checks++; if (o_Fetch_Count !== exp_cnt()) begin errors++; $display("FAIL mis_count: got %0d expected %0d", o_Fetch_Count, exp_cnt()); end
        for (int i = 0; i < 4; i++) begin
            i_Imem_Gnt    = 1'b1;
            i_Imem_Rvalid = 1'b1;
            i_Ready       = 1'b1;
            i_Next        = 32'h0000_0100;
            step();
            checks++;
            if (o_Imem_Req !== 1'b0 || o_Valid !== 1'b0 || o_Pc !== prior || o_Misaligned !== 1'b1 || o_Fetch_Count !== exp_cnt()) begin
                errors++;
                $display("FAIL mis_frozen: got req=%b valid=%b pc=%h mis=%b cnt=%0d expected 0/0/%h/1/%0d", o_Imem_Req, o_Valid, o_Pc, o_Misaligned, o_Fetch_Count, prior, exp_cnt());
            end
        end
        i_Imem_Gnt    = 1'b0;
        i_Imem_Rvalid = 1'b0;
        i_Ready       = 1'b0;
    endtask

    task automatic test_timeout();
        apply_reset();
        i_Imem_Gnt = 1'b1;
        step();
        i_Imem_Gnt = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        checks++; if (o_Timeout !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b expected 0", o_Timeout); end
        step();
        checks++; if (o_Timeout !== 1'b1 || o_Misaligned !== 1'b0) begin errors++; $display("FAIL tmo_flag: got tmo=%b mis=%b expected 1/0", o_Timeout, o_Misaligned); end
        i_Imem_Rvalid = 1'b1;
        i_Imem_Rdata  = 32'h5555_AAAA;
        step();
        step();
        i_Imem_Rvalid = 1'b0;
        checks++; if (o_Valid !== 1'b0 || o_Imem_Req !== 1'b0 || o_Timeout !== 1'b1) begin errors++; $display("FAIL tmo_frozen: got valid=%b req=%b tmo=%b expected 0/0/1", o_Valid, o_Imem_Req, o_Timeout); end

        // rvalid on the limit cycle must be accepted.
        apply_reset();
        i_Imem_Gnt = 1'b1;
        step();
        i_Imem_Gnt = 1'b0;
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        i_Imem_Rvalid = 1'b1;
        i_Imem_Rdata  = 32'h0BAD_F00D;
        step();
        i_Imem_Rvalid = 1'b0;
        checks++; if (o_Valid !== 1'b1 || o_Timeout !== 1'b0 || o_Instruction !== 32'h0BAD_F00D) begin errors++; $display("FAIL tmo_limit_rvalid: got valid=%b tmo=%b instr=%h expected 1/0/0badf00d", o_Valid, o_Timeout, o_Instruction); end
    endtask

    task automatic test_reset_in_wait();
        // Leave HOLD from the previous test, then go back into WAIT.
        i_Ready = 1'b1;
        i_Next  = 32'h0000_0010;
        step();
        i_Ready    = 1'b0;
        i_Imem_Gnt = 1'b1;
        step();
        i_Imem_Gnt = 1'b0;
        step();
        checks++; if (o_Fetch_Count !== CNT_W'(1) || o_Imem_Addr !== 32'h10) begin errors++; $display("FAIL rst_wait_pre: got cnt=%0d addr=%h expected 1/10", o_Fetch_Count, o_Imem_Addr); end
        i_Reset_n = 1'b0;
        #2;
        checks++; if (o_Imem_Req !== 1'b1 || o_Pc !== RESET_PC || o_Fetch_Count !== '0 || o_Valid !== 1'b0) begin errors++; $display("FAIL rst_wait_async: got req=%b pc=%h cnt=%0d valid=%b expected 1/%h/0/0", o_Imem_Req, o_Pc, o_Fetch_Count, o_Valid, RESET_PC); end
        step();
        i_Reset_n     = 1'b1;
        i_Imem_Rvalid = 1'b1;
        i_Imem_Rdata  = 32'hBAAD_BAAD;
        step();
        i_Imem_Rvalid = 1'b0;
        m_pc  = RESET_PC;
        m_cnt = 0;
        checks++;
        if (o_Valid !== 1'b0 || o_Imem_Req !== 1'b1 || o_Imem_Addr !== RESET_PC || o_Instruction !== 32'h0 || o_Fetch_Count !== '0 || o_Misaligned !== 1'b0 || o_Timeout !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait_stale: got valid=%b req=%b addr=%h instr=%h cnt=%0d mis=%b tmo=%b expected 0/1/%h/0/0/0/0", o_Valid, o_Imem_Req, o_Imem_Addr, o_Instruction, o_Fetch_Count, o_Misaligned, o_Timeout, RESET_PC);
        end
        do_fetch(32'h7777_0003);
        checks++; if (o_Valid !== 1'b1 || o_Instruction !== 32'h7777_0003 || o_Pc !== RESET_PC) begin errors++; $display("FAIL rst_wait_refetch: got valid=%b instr=%h pc=%h expected 1/77770003/%h", o_Valid, o_Instruction, o_Pc, RESET_PC); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_hold_stall();
        test_gnt_delay();
        test_random();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
